// File: rtl/odata_sched_pkg.sv
// Shared types and constants for the odata pattern scheduler.
//   state_t      : scheduler FSM states
//   IDLE_VAL_DEF : default odata value driven while not running
package odata_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [3:0] IDLE_VAL_DEF = 4'h0;

endpackage

// File: rtl/odata_pattern_table.sv
// Pattern table: DEPTH entries of {pattern, hold}, one synchronous write
// port and one combinational read port. Entries reset to {IDLE_VAL, 0}.
//   clk, rst_n                      : clock, async active-low reset
//   wr_en/wr_addr/wr_pattern/wr_hold: write port
//   rd_addr/rd_pattern/rd_hold      : combinational read port
module odata_pattern_table #(
  parameter int         DEPTH    = 8,
  parameter int         HOLD_W   = 8,
  parameter int         AW       = 3,
  parameter logic [3:0] IDLE_VAL = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [3:0]        wr_pattern,
  input  logic [HOLD_W-1:0] wr_hold,
  input  logic [AW-1:0]     rd_addr,
  output logic [3:0]        rd_pattern,
  output logic [HOLD_W-1:0] rd_hold
);

  logic [DEPTH-1:0][3:0]        pat_mem;
  logic [DEPTH-1:0][HOLD_W-1:0] hold_mem;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pat_mem[i]  <= IDLE_VAL;
        hold_mem[i] <= '0;
      end else if (wr_en && (wr_addr == AW'(i))) begin
        pat_mem[i]  <= wr_pattern;
        hold_mem[i] <= wr_hold;
      end
    end
  end

  assign rd_pattern = pat_mem[rd_addr];
  assign rd_hold    = hold_mem[rd_addr];

endmodule

// File: rtl/odata_pattern_sched.sv
// Odata pattern scheduler: steps through a programmable table of 4-bit
// patterns, holding each for hold+1 cycles, for repeat_num passes (0 = until
// stop). One FINISH cycle with done=1 ends every sequence except a reset.
//   sys_clock, rst_n            : clock, async active-low reset
//   cfg_valid/ready/addr/pattern/hold : table write (accepted only in IDLE)
//   start, stop, repeat_num, last_step: sequence control
//   busy, done, odata           : status and registered pattern output
module odata_pattern_sched
  import odata_sched_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter int         HOLD_W   = 8,
  parameter int         REP_W    = 8,
  parameter logic [3:0] IDLE_VAL = IDLE_VAL_DEF
) (
  input  logic                                  sys_clock,
  input  logic                                  rst_n,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [((DEPTH>1)?$clog2(DEPTH):1)-1:0] cfg_addr,
  input  logic [3:0]                            cfg_pattern,
  input  logic [HOLD_W-1:0]                     cfg_hold,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic [REP_W-1:0]                      repeat_num,
  input  logic [((DEPTH>1)?$clog2(DEPTH):1)-1:0] last_step,
  output logic                                  busy,
  output logic                                  done,
  output logic [3:0]                            odata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state, state_n;
  logic [AW-1:0]     step, step_n, last_q, last_n;
  logic [HOLD_W-1:0] hcnt, hcnt_n, hold_lim;
  logic [REP_W-1:0]  pass_q, pass_n;
  logic              rep_nz, rep_nz_n;
  logic [3:0]        rd_pattern;
  logic [HOLD_W-1:0] rd_hold;

  // Ready is gated by rst_n so nothing is offered while reset is held.
  assign cfg_ready = (state == S_IDLE) && rst_n;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FINISH);

  odata_pattern_table #(
    .DEPTH    (DEPTH),
    .HOLD_W   (HOLD_W),
    .AW       (AW),
    .IDLE_VAL (IDLE_VAL)
  ) u_table (
    .clk        (sys_clock),
    .rst_n      (rst_n),
    .wr_en      (cfg_valid && cfg_ready),
    .wr_addr    (cfg_addr),
    .wr_pattern (cfg_pattern),
    .wr_hold    (cfg_hold),
    .rd_addr    (step_n),
    .rd_pattern (rd_pattern),
    .rd_hold    (rd_hold)
  );

  always_comb begin
    state_n  = state;
    step_n   = step;
    hcnt_n   = hcnt;
    pass_n   = pass_q;
    rep_nz_n = rep_nz;
    last_n   = last_q;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_n  = S_RUN;
          step_n   = '0;
          hcnt_n   = '0;
          pass_n   = repeat_num;
          rep_nz_n = |repeat_num;
          last_n   = last_step;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_n = S_FINISH;
        end else if (hcnt == hold_lim) begin
          hcnt_n = '0;
          if (step == last_q) begin
            step_n = '0;
            // Infinite mode never touches the pass counter.
            if (rep_nz) begin
              pass_n = pass_q - REP_W'(1);
              if (pass_q == REP_W'(1)) state_n = S_FINISH;
            end
          end else begin
            step_n = step + AW'(1);
          end
        end else begin
          // hcnt stops at hold_lim, so it can never wrap.
          hcnt_n = hcnt + HOLD_W'(1);
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Table is read at the next step index so odata and the hold limit are
  // registered alongside the step they belong to.
  always_ff @(posedge sys_clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      step     <= '0;
      hcnt     <= '0;
      hold_lim <= '0;
      pass_q   <= '0;
      rep_nz   <= 1'b0;
      last_q   <= '0;
      odata    <= IDLE_VAL;
    end else begin
      state    <= state_n;
      step     <= step_n;
      hcnt     <= hcnt_n;
      hold_lim <= rd_hold;
      pass_q   <= pass_n;
      rep_nz   <= rep_nz_n;
      last_q   <= last_n;
      odata    <= (state_n == S_RUN) ? rd_pattern : IDLE_VAL;
    end
  end

endmodule

// File: tb/tb_odata_pattern_sched.sv
module tb_odata_pattern_sched;

  localparam int DEPTH = 8;
  localparam int HW    = 8;
  localparam int RW    = 8;

  logic       sys_clock = 1'b0;
  logic       rst_n     = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_addr  = '0;
  logic [3:0] cfg_pattern = '0;
  logic [HW-1:0] cfg_hold = '0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic [RW-1:0] repeat_num = '0;
  logic [2:0] last_step = '0;
  logic       busy, done;
  logic [3:0] odata;

  odata_pattern_sched #(.DEPTH(DEPTH), .HOLD_W(HW), .REP_W(RW), .IDLE_VAL(4'h0)) dut (
    .sys_clock(sys_clock), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_pattern(cfg_pattern), .cfg_hold(cfg_hold),
    .start(start), .stop(stop), .repeat_num(repeat_num), .last_step(last_step),
    .busy(busy), .done(done), .odata(odata)
  );

  always #5 sys_clock = ~sys_clock;

  int n_chk = 0;
  int n_err = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  typedef struct packed { logic [3:0] odata; logic done; } exp_t;
  exp_t sb_q[$];

  logic [3:0]    sh_pat [DEPTH];
  logic [HW-1:0] sh_hold[DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: expected per-busy-cycle {odata, done} sequence.
  task automatic push_seq(input int rep, input int last, input int stop_run);
    int step = 0, hc = 0, passes = rep, runs = 0;
    exp_t e;
    while (runs < 1000) begin
      e.odata = sh_pat[step]; e.done = 1'b0;
      sb_q.push_back(e);
      runs++;
      if (stop_run > 0 && runs == stop_run) break;
      if (hc == int'(sh_hold[step])) begin
        hc = 0;
        if (step == last) begin
          step = 0;
          if (rep != 0) begin
            passes--;
            if (passes == 0) break;
          end
        end else step++;
      end else hc++;
    end
    e.odata = 4'h0; e.done = 1'b1;
    sb_q.push_back(e);
  endtask

  always @(negedge sys_clock) begin
    if (busy) begin
      busy_cnt++;
      if (done) done_cnt++;
      if (sb_q.size() == 0) chk("sb_unexpected_busy", 1, 0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_odata", odata, e.odata);
        chk("sb_done", done, e.done);
      end
    end else begin
      chk("idle_odata", odata, 4'h0);
      chk("idle_done", done, 1'b0);
    end
  end

  task automatic tick();
    @(posedge sys_clock); #1;
  endtask

  task automatic cfg_wr(input int a, input logic [3:0] p, input logic [HW-1:0] h);
    cfg_valid = 1'b1; cfg_addr = 3'(a); cfg_pattern = p; cfg_hold = h;
    #1 chk("cfg_ready_idle", cfg_ready, 1'b1);
    tick();
    cfg_valid = 1'b0;
    sh_pat[a] = p; sh_hold[a] = h;
  endtask

  task automatic do_start(input int rep, input int last);
    repeat_num = RW'(rep); last_step = 3'(last); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 300; i++) begin
      if (!busy) break;
      tick();
    end
    if (i >= 300) chk({tag, "_timeout"}, 1, 0);
    tick(); tick();
    chk({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin sh_pat[i] = 4'h0; sh_hold[i] = '0; end

    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_odata", odata, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", cfg_ready, 1);

    cfg_wr(0, 4'h1, 0);
    cfg_wr(1, 4'h2, 1);
    cfg_wr(2, 4'h4, 0);

    // Single pass: 1,2,2,4 then done
    push_seq(1, 2, 0);
    done_cnt = 0;
    do_start(1, 2);
    wait_idle("rep1");
    chk("rep1_done_cnt", done_cnt, 1);

    // Two passes, busy for 9 cycles
    push_seq(2, 2, 0);
    busy_cnt = 0; done_cnt = 0;
    do_start(2, 2);
    wait_idle("rep2");
    chk("rep2_busy_cycles", busy_cnt, 9);
    chk("rep2_done_cnt", done_cnt, 1);

    // Infinite mode, stop sampled at end of 20th RUN cycle
    push_seq(0, 2, 20);
    done_cnt = 0;
    do_start(0, 2);
    repeat (19) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle("stop20");
    chk("stop20_done_cnt", done_cnt, 1);

    // Write attempt during RUN must be refused
    push_seq(1, 2, 0);
    do_start(1, 2);
    cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_pattern = 4'hF; cfg_hold = '0;
    #1 chk("run_cfg_ready", cfg_ready, 0);
    tick(); tick();
    cfg_valid = 1'b0;
    wait_idle("run_wr");
    push_seq(1, 2, 0);
    do_start(1, 2);
    wait_idle("run_wr_replay");

    // start and stop together in IDLE
    busy_cnt = 0; done_cnt = 0;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick(); tick();
    chk("startstop_busy_cnt", busy_cnt, 0);
    chk("startstop_busy", busy, 0);
    chk("startstop_done_cnt", done_cnt, 0);

    // Reset in the middle of step 1
    done_cnt = 0;
    do_start(0, 2);
    sb_q.push_back('{odata: 4'h1, done: 1'b0});
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_odata", odata, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cfg_ready, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin sh_pat[i] = 4'h0; sh_hold[i] = '0; end
    chk("midrst_sb_empty", sb_q.size(), 0);
    chk("midrst_done_cnt", done_cnt, 0);
    tick();
    chk("midrst_ready_after", cfg_ready, 1);
    push_seq(1, 2, 0);
    busy_cnt = 0;
    do_start(1, 2);
    wait_idle("after_rst");
    chk("after_rst_busy_cycles", busy_cnt, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/odata_pattern_sched.md
ODATA_PATTERN_SCHED -- requirements
Module: odata_pattern_sched

Interface
REQ-001 Parameter DEPTH, default 8, number of pattern table entries (power of two).
REQ-002 Parameter HOLD_W, default 8, width of per-step hold count.
REQ-003 Parameter REP_W, default 8, width of repeat count.
REQ-004 Parameter IDLE_VAL, default 4'h0, odata value when not running.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: sys_clock is the single clock and rst_n is the asynchronous active-low reset.
REQ-006 sys_clock  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 cfg_valid  input  1  table write request.
REQ-009 cfg_ready  output  1  table write accepted when high with cfg_valid.
REQ-010 cfg_addr  input  log2(DEPTH)  table entry index.
REQ-011 cfg_pattern  input  4  odata value for entry.
REQ-012 cfg_hold  input  HOLD_W  extra hold cycles for entry.
REQ-013 start  input  1  begin sequence (level sampled).
REQ-014 stop  input  1  abort sequence.
REQ-015 repeat_num  input  REP_W  passes to run; 0 = run until stop.
REQ-016 last_step  input  log2(DEPTH)  final table index of a pass.
REQ-017 busy  output  1  high in RUN and FINISH.
REQ-018 done  output  1  one-cycle pulse at sequence end.
REQ-019 odata  output  4  registered sequenced pattern.

Function
REQ-020 FSM states SHALL be IDLE, RUN, FINISH; reset state IDLE.
REQ-021 cfg_ready SHALL be 1 only in IDLE; a write occurs on cfg_valid&&cfg_ready; writes outside IDLE are not accepted.
REQ-022 In IDLE, start=1 and stop=0 SHALL latch repeat_num, last_step, step=0, hold counter=0 and go to RUN next cycle.
REQ-023 In IDLE, start and stop both high SHALL leave the FSM in IDLE (stop wins).
REQ-024 start while in RUN or FINISH SHALL be ignored.
REQ-025 In RUN odata SHALL equal pattern[step] from the first RUN cycle (one cycle after start sampled); each step lasts hold[step]+1 cycles.
REQ-026 After the last cycle of step last_step, step SHALL wrap to 0 and the pass counter decrement; when latched repeat_num is nonzero and the counter reaches 0, go to FINISH.
REQ-027 Latched repeat_num=0 SHALL wrap indefinitely until stop.
REQ-028 stop in RUN SHALL go to FINISH next cycle regardless of step or hold position.
REQ-029 FINISH SHALL last exactly one cycle with done=1, odata=IDLE_VAL, then return to IDLE.
REQ-030 In IDLE odata SHALL be IDLE_VAL; busy=0 in IDLE.
REQ-031 last_step SHALL be used modulo DEPTH; hold counter SHALL compare at full HOLD_W width without overflow.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, odata=IDLE_VAL, busy=0, done=0, cfg_ready=0 while asserted, counters=0.
REQ-033 Pattern table contents SHALL reset to pattern=IDLE_VAL, hold=0.
REQ-034 Reset asserted mid-RUN SHALL abort without a done pulse; cfg_ready=1 from first cycle after release.

Structure
REQ-035 Package odata_sched_pkg SHALL hold the state enum type and IDLE_VAL default constant.
REQ-036 Table storage SHALL be a sub-module odata_pattern_table (register array, one write port, one combinational read port).

Verification
REQ-037 Write entries 0..2 = (4'h1,hold 0),(4'h2,hold 1),(4'h4,hold 0); last_step=2, repeat_num=1, start -> odata 1,2,2,4 then done pulse, odata=0.
REQ-038 Same table, repeat_num=2 -> odata 1,2,2,4,1,2,2,4 then single done pulse; busy high for 9 cycles.
REQ-039 repeat_num=0, stop after 20 RUN cycles -> pattern repeats every 4 cycles, FINISH next cycle, done=1 once.
REQ-040 cfg_valid during RUN with new entry 0=4'hF -> cfg_ready=0, odata never shows F in that sequence.
REQ-041 start and stop high together in IDLE -> busy stays 0, odata stays 0, no done.
REQ-042 rst_n low in middle of step 1 -> odata=0 immediately (async), no done, next start replays from reset table values (odata=0, 1-cycle steps).
